// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from incoming active-low hsync/vsync, measures
// line and frame periods, and locks once the timing matches the configured mode.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int XBITS       = 10,
  parameter int YBITS       = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pix_en,
  input  logic             hsync,
  input  logic             vsync,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic             activevideo,
  output logic             locked,
  output logic [11:0]      h_period,
  output logic [11:0]      v_period,
  output logic             sync_err
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int GW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_HUNT, S_TRACK, S_LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [GW-1:0]    good_reg, good_next;
  logic             frame_bad_reg, frame_bad_next;
  logic             err_next;
  logic             sync_err_reg;
  logic             hs_prev_reg, vs_prev_reg;
  logic             h_seen_reg, v_seen_reg;
  logic [XBITS-1:0] x_reg;
  logic [YBITS-1:0] y_reg;
  logic [11:0]      h_cnt_reg, v_cnt_reg;
  logic [11:0]      h_period_reg, v_period_reg;

  logic h_fall, v_fall, x_last, y_last;
  logic h_report, v_report, h_bad, v_bad, h_tmo, v_tmo;
  logic [11:0] h_cnt_inc, v_cnt_inc;

  assign h_fall    = pix_en && hs_prev_reg && !hsync;
  assign v_fall    = pix_en && vs_prev_reg && !vsync;
  assign x_last    = (x_reg == XBITS'(H_TOTAL - 1));
  assign y_last    = (y_reg == YBITS'(V_TOTAL - 1));
  assign h_cnt_inc = (h_cnt_reg == CNT_MAX) ? h_cnt_reg : h_cnt_reg + 12'd1;
  assign v_cnt_inc = (v_cnt_reg == CNT_MAX) ? v_cnt_reg : v_cnt_reg + 12'd1;
  assign h_report  = h_fall && h_seen_reg;
  assign v_report  = v_fall && v_seen_reg;
  assign h_bad     = h_report && (h_cnt_reg != 12'(H_TOTAL));
  assign v_bad     = v_report && (v_cnt_reg != 12'(V_TOTAL));
  // Timeouts fire on the tick a counter steps onto twice the nominal period.
  assign h_tmo     = pix_en && !h_fall && (h_cnt_reg == 12'(2 * H_TOTAL - 1));
  assign v_tmo     = h_fall && !v_fall && (v_cnt_reg == 12'(2 * V_TOTAL - 1));

  always_comb begin
    state_next     = state_reg;
    good_next      = good_reg;
    frame_bad_next = frame_bad_reg;
    err_next       = 1'b0;
    case (state_reg)
      S_HUNT: begin
        if (v_fall) begin
          state_next     = S_TRACK;
          good_next      = '0;
          frame_bad_next = 1'b0;
        end
      end
      default: begin
        if (h_tmo || v_tmo) begin
          err_next   = 1'b1;
          state_next = S_HUNT;
          good_next  = '0;
        end else if (h_bad || v_bad) begin
          err_next       = 1'b1;
          state_next     = S_TRACK;
          good_next      = '0;
          // A bad line on the closing vsync tick belongs to the frame just ended.
          frame_bad_next = !v_fall;
        end else if (v_fall) begin
          frame_bad_next = 1'b0;
          if (!frame_bad_reg && v_report && state_reg == S_TRACK) begin
            if (good_reg == GW'(LOCK_FRAMES - 1)) begin
              state_next = S_LOCKED;
              good_next  = GW'(LOCK_FRAMES);
            end else begin
              good_next = good_reg + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= S_HUNT;
      good_reg      <= '0;
      frame_bad_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
      hs_prev_reg   <= 1'b1;
      vs_prev_reg   <= 1'b1;
      h_seen_reg    <= 1'b0;
      v_seen_reg    <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      h_period_reg  <= '0;
      v_period_reg  <= '0;
    end else begin
      sync_err_reg <= err_next;
      if (pix_en) begin
        state_reg     <= state_next;
        good_reg      <= good_next;
        frame_bad_reg <= frame_bad_next;
        hs_prev_reg   <= hsync;
        vs_prev_reg   <= vsync;
        if (h_fall) begin
          x_reg      <= XBITS'(HS_START);
          h_cnt_reg  <= 12'd1;
          h_seen_reg <= 1'b1;
          if (h_seen_reg) h_period_reg <= h_cnt_reg;
        end else begin
          x_reg     <= x_last ? '0 : x_reg + 1'b1;
          h_cnt_reg <= h_cnt_inc;
        end
        if (v_fall) begin
          y_reg      <= YBITS'(VS_START);
          v_cnt_reg  <= h_fall ? 12'd1 : 12'd0;
          v_seen_reg <= 1'b1;
          if (v_seen_reg) v_period_reg <= v_cnt_reg;
        end else begin
          if (!h_fall && x_last) y_reg <= y_last ? '0 : y_reg + 1'b1;
          if (h_fall) v_cnt_reg <= v_cnt_inc;
        end
      end
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign h_period    = h_period_reg;
  assign v_period    = v_period_reg;
  assign sync_err    = sync_err_reg;
  assign locked      = (state_reg == S_LOCKED);
  assign activevideo = locked && (x_reg < XBITS'(H_ACTIVE)) && (y_reg < YBITS'(V_ACTIVE));

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives a reduced-size VGA-style sync stream into the decoder and checks
// recovered coordinates, periods, lock behaviour and error pulses.
module tb_vga_sync_decoder;

  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 16
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 10
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic resetn, pix_en, hsync, vsync;
  logic [9:0] x, y;
  logic activevideo, locked, sync_err;
  logic [11:0] h_period, v_period;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .XBITS(10), .YBITS(10), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .activevideo(activevideo), .locked(locked),
    .h_period(h_period), .v_period(v_period), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] ex;
    logic [9:0] ey;
    logic       eav;
  } exp_t;

  exp_t sb_q[$];
  int total = 0, bad = 0;
  int gx = 0, gy = 0, line_len = HT, frame_lines = VT;
  logic hs_last = 1'b1, vs_last = 1'b1, force_hs = 1'b0, check_xy = 1'b0;
  logic hfall_now, vfall_now, err_seen;
  int hfalls = 0, vfalls = 0, err_pulses = 0, av_count = 0;

  // One pixel tick: pix_en high for one clk, then a clk with pix_en low.
  task automatic step();
    logic hs_v, vs_v;
    exp_t e;
    @(negedge clk);
    total++;
    if (sync_err !== 1'b0) begin
      bad++; $display("FAIL sync_err_width: got %0b required 0", sync_err);
    end
    hs_v = force_hs || !(gx >= HS_START && gx < HS_START + H_SYNC);
    vs_v = !(gy >= VS_START && gy < VS_START + V_SYNC);
    hfall_now = hs_last && !hs_v;
    vfall_now = vs_last && !vs_v;
    hs_last = hs_v;
    vs_last = vs_v;
    hsync = hs_v; vsync = vs_v; pix_en = 1'b1;
    if (check_xy) sb_q.push_back('{ex: 10'(gx), ey: 10'(gy),
                                   eav: (gx < H_ACTIVE) && (gy < V_ACTIVE)});
    @(negedge clk);
    pix_en = 1'b0;
    err_seen = sync_err;
    if (sync_err) err_pulses++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (x !== e.ex || y !== e.ey || activevideo !== e.eav) begin
        bad++;
        $display("FAIL xy_av: got x=%0d y=%0d av=%0b required x=%0d y=%0d av=%0b",
                 x, y, activevideo, e.ex, e.ey, e.eav);
      end
      if (activevideo) av_count++;
    end
    if (hfall_now) hfalls++;
    if (vfall_now) vfalls++;
    if (gx == line_len - 1) begin
      gx = 0;
      line_len = HT;
      if (gy == frame_lines - 1) begin
        gy = 0;
        frame_lines = VT;
      end else gy++;
    end else gx++;
  endtask

  task automatic run_vfalls(input int n);
    int target, k;
    target = vfalls + n; k = 0;
    while (vfalls < target && k < BUDGET) begin step(); k++; end
    if (vfalls < target) begin
      total++; bad++; $display("FAIL vfall_wait: got %0d required %0d", vfalls, target);
    end
  endtask

  task automatic run_hfalls(input int n);
    int target, k;
    target = hfalls + n; k = 0;
    while (hfalls < target && k < BUDGET) begin step(); k++; end
    if (hfalls < target) begin
      total++; bad++; $display("FAIL hfall_wait: got %0d required %0d", hfalls, target);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; pix_en = 1'b1; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (x !== 0 || y !== 0 || h_period !== 0 || v_period !== 0 ||
        locked !== 0 || activevideo !== 0 || sync_err !== 0) begin
      bad++;
      $display("FAIL reset_state: got x=%0d y=%0d hp=%0d vp=%0d lk=%0b av=%0b err=%0b required all 0",
               x, y, h_period, v_period, locked, activevideo, sync_err);
    end
    pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_ideal();
    run_vfalls(2);
    total++;
    if (h_period !== 12'(HT) || v_period !== 12'(VT) || locked !== 1'b0) begin
      bad++;
      $display("FAIL ideal_periods: got hp=%0d vp=%0d lk=%0b required hp=%0d vp=%0d lk=0",
               h_period, v_period, locked, HT, VT);
    end
    run_vfalls(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL ideal_lock: got %0b required 1", locked); end
    check_xy = 1'b1; av_count = 0;
    run_vfalls(1);
    check_xy = 1'b0;
    total++;
    if (av_count != H_ACTIVE * V_ACTIVE) begin
      bad++; $display("FAIL ideal_av_count: got %0d required %0d", av_count, H_ACTIVE * V_ACTIVE);
    end
  endtask

  task automatic test_pix_en_hold();
    logic [9:0] sx, sy;
    logic [11:0] shp, svp;
    logic err_any;
    run_hfalls(1);
    repeat (3) step();
    sx = x; sy = y; shp = h_period; svp = v_period; err_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hsync = i[0]; vsync = i[1];
      err_any = err_any | sync_err;
    end
    @(negedge clk);
    total++;
    if (x !== sx || y !== sy || h_period !== shp || v_period !== svp || err_any !== 1'b0) begin
      bad++;
      $display("FAIL pix_en_hold: got x=%0d y=%0d hp=%0d vp=%0d err=%0b required x=%0d y=%0d hp=%0d vp=%0d err=0",
               x, y, h_period, v_period, err_any, sx, sy, shp, svp);
    end
    run_hfalls(2);
    total++;
    if (h_period !== 12'(HT) || locked !== 1'b1) begin
      bad++; $display("FAIL pix_en_resume: got hp=%0d lk=%0b required hp=%0d lk=1", h_period, locked, HT);
    end
  endtask

  task automatic test_short_line();
    run_vfalls(1);
    line_len = HT - 1;
    run_hfalls(2);
    total++;
    if (err_seen !== 1'b1 || h_period !== 12'(HT - 1) || locked !== 1'b0) begin
      bad++;
      $display("FAIL short_line: got err=%0b hp=%0d lk=%0b required err=1 hp=%0d lk=0",
               err_seen, h_period, locked, HT - 1);
    end
    run_vfalls(2);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL short_line_early_lock: got %0b required 0", locked); end
    run_vfalls(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL short_line_relock: got %0b required 1", locked); end
    check_xy = 1'b1; av_count = 0;
    run_vfalls(1);
    check_xy = 1'b0;
    total++;
    if (av_count != H_ACTIVE * V_ACTIVE) begin
      bad++; $display("FAIL relock_av_count: got %0d required %0d", av_count, H_ACTIVE * V_ACTIVE);
    end
  endtask

  task automatic test_hsync_timeout();
    logic av_any;
    run_vfalls(1);
    err_pulses = 0;
    force_hs = 1'b1;
    for (int i = 0; i < 2 * HT + 4; i++) step();
    force_hs = 1'b0;
    av_any = activevideo;
    total++;
    if (err_pulses != 1 || locked !== 1'b0 || av_any !== 1'b0) begin
      bad++;
      $display("FAIL hsync_timeout: got pulses=%0d lk=%0b av=%0b required pulses=1 lk=0 av=0",
               err_pulses, locked, av_any);
    end
    run_vfalls(2);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL timeout_hunt: got %0b required 0", locked); end
    run_vfalls(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL timeout_relock: got %0b required 1", locked); end
  endtask

  task automatic test_short_frame();
    frame_lines = VT - 1;
    run_vfalls(1);
    total++;
    if (v_period !== 12'(VT - 1) || err_seen !== 1'b1 || locked !== 1'b0) begin
      bad++;
      $display("FAIL short_frame: got vp=%0d err=%0b lk=%0b required vp=%0d err=1 lk=0",
               v_period, err_seen, locked, VT - 1);
    end
    run_vfalls(2);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL short_frame_relock: got %0b required 1", locked); end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    k = 0;
    // Reset while both syncs are high so no spurious edge follows release.
    while (!(gx == 3 && gy == 2) && k < BUDGET) begin step(); k++; end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL pre_reset_lock: got %0b required 1", locked); end
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    total++;
    if (x !== 0 || y !== 0 || h_period !== 0 || v_period !== 0 ||
        locked !== 0 || activevideo !== 0 || sync_err !== 0) begin
      bad++;
      $display("FAIL mid_reset_state: got x=%0d y=%0d hp=%0d vp=%0d lk=%0b av=%0b err=%0b required all 0",
               x, y, h_period, v_period, locked, activevideo, sync_err);
    end
    run_vfalls(2);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL mid_reset_early_lock: got %0b required 0", locked); end
    run_vfalls(1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL mid_reset_relock: got %0b required 1", locked); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_pix_en_hold();
    test_short_line();
    test_hsync_timeout();
    test_short_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. It samples active-low hsync/vsync at pixel rate and recovers the pixel coordinates x/y and an activevideo flag. It also measures line and frame periods and asserts a lock flag once the incoming timing matches the 640x480 mode. It is used for frame capture and as an on-chip checker of the display timing path.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
XBITS, 10, width of x
YBITS, 10, width of y
LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
pix_en  input  1  pixel-rate strobe, one clk wide (e.g. every 4th clk)
hsync  input  1  horizontal sync, active low
vsync  input  1  vertical sync, active low
x  output  XBITS  recovered column
y  output  YBITS  recovered row
activevideo  output  1  locked && x<H_ACTIVE && y<V_ACTIVE
locked  output  1  timing matches parameters
h_period  output  12  last measured line length in pixel ticks
v_period  output  12  last measured frame length in lines
sync_err  output  1  one-clk pulse on any timing mismatch or timeout

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL (525); HS_START=H_ACTIVE+H_FP (656); VS_START=V_ACTIVE+V_FP (490).
- Reset (resetn=0 at posedge clk): x=0, y=0, h_period=0, v_period=0, locked=0, activevideo=0, sync_err=0. Previous-sample regs=1, internal counters=0, first-edge flags cleared. Reset mid-frame discards all state.
- All state updates only on clk edges where pix_en=1, except the sync_err clear. sync_err is high for exactly one clk, then returns to 0.
- Edge detect: hsync/vsync are registered on pix_en. A falling edge is prev=1 and cur=0 at the same pix_en.
- x: on an hsync falling edge, x<=HS_START. Otherwise x<=(x==H_TOTAL-1)?0:x+1. Latency: x reflects the sample taken on the same pix_en, visible one clk later.
- y: on a vsync falling edge, y<=VS_START. Otherwise, when x wraps H_TOTAL-1->0, y<=(y==V_TOTAL-1)?0:y+1. If the vsync edge and the x wrap occur together, the vsync edge wins.
- Line measure: h_cnt counts pix_en ticks since the last hsync fall, saturating at 4095. On each fall, h_period<=h_cnt and h_cnt<=1. The first fall after reset only restarts the count; no period is reported and no check is made.
- Frame measure: v_cnt counts hsync falls since the last vsync fall, saturating. On each vsync fall, v_period<=v_cnt. The first vsync fall after reset only restarts the count.
- Lock FSM: HUNT -> TRACK -> LOCKED.
  - HUNT: wait for the first vsync fall, then go to TRACK with good=0.
  - TRACK: a frame is good if every reported h_period==H_TOTAL and v_period==V_TOTAL. At each vsync fall that closes a good frame, good++. When good reaches LOCK_FRAMES, go to LOCKED and set locked=1.
  - Any mismatch in TRACK or LOCKED: sync_err pulse, good=0, locked=0, state->TRACK.
  - Timeout: h_cnt reaching 2*H_TOTAL, or v_cnt reaching 2*V_TOTAL. Response: sync_err pulse, state->HUNT, locked=0.
- Coordinates free-run while unlocked. activevideo is 0 whenever locked=0.

Test Plan:
- Ideal 640x480 stream from the VGA timing generator with pix_en every 4th clk -> h_period=800 and v_period=525 after the 2nd frame; locked=1 at the vsync fall closing the 3rd frame (the first frame only syncs); decoder x/y equal generator x/y each pixel once locked; activevideo high for exactly 640x480 pixels per frame.
- One line shortened to 799 pixels while locked -> sync_err one clk, locked=0, h_period=799; relock after 2 further good frames.
- hsync held high for 1600 pixel ticks -> sync_err pulse, FSM in HUNT, locked=0, activevideo=0.
- Frame with 524 lines -> v_period=524, sync_err pulse, locked=0.
- resetn=0 for one clk mid-frame while locked -> all outputs zero next clk; relock requires the full HUNT/TRACK sequence again.
- pix_en held low with sync toggling -> x, y and counters unchanged.
